// File: rtl/seq_mul_pkg.sv
// Shared state encoding, default width and sign helper for seq_mul.
// The optional early-exit build is selected with SEQ_MUL_EARLY_EXIT_EN.
package seq_mul_pkg;

    localparam int SEQ_MUL_WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Two's-complement negate when neg is set; callers truncate to their width.
    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: accumulator, multiplier shift register, one adder; one step per enabled edge.
// No backpressure: load/step are driven by the controller; SEQ_MUL_EARLY_EXIT_EN adds a zero-multiplier flag.
module seq_mul_dp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_nxt_o
`ifdef SEQ_MUL_EARLY_EXIT_EN
    ,
    output logic               mplier_nxt_zero_o
`endif
);

    // Bit 0 of the accumulator is always a shifted-out zero, so it is not stored.
    logic [2*WIDTH-1:1] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     sum;

    assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_nxt_o = {sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign mplier_nxt_zero_o = (mplier_q[WIDTH-1:1] == '0);
`endif

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
        end else if (step_i) begin
            acc_d    = acc_nxt_o[2*WIDTH-1:1];
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Iterative WIDTH x WIDTH multiplier, signed/unsigned; done one cycle after WIDTH RUN edges.
// start is ignored while busy (no queueing); SEQ_MUL_EARLY_EXIT_EN finishes once the multiplier runs out.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 load, step, last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_nxt, prod;

    assign a_mag = WIDTH'(cond_neg(32'(a), signed_mode & a[WIDTH-1]));
    assign b_mag = WIDTH'(cond_neg(32'(b), signed_mode & b[WIDTH-1]));

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic mplier_nxt_zero;

    seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_i           (load),
        .step_i           (step),
        .mcand_i          (a_mag),
        .mplier_i         (b_mag),
        .acc_nxt_o        (acc_nxt),
        .mplier_nxt_zero_o(mplier_nxt_zero)
    );

    // An early finish leaves the product sitting high; realign by the skipped steps.
    assign last = (cnt_q == LAST) || mplier_nxt_zero;
    assign prod = acc_nxt >> (LAST - cnt_q);
`else
    seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (a_mag),
        .mplier_i (b_mag),
        .acc_nxt_o(acc_nxt)
    );

    assign last = (cnt_q == LAST);
    assign prod = acc_nxt;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    sign_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    result_d = (2*WIDTH)'(cond_neg(32'(prod), sign_q));
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul at WIDTH=4: integer-arithmetic reference checked every cycle plus directed literals.
module tb_seq_mul;

    localparam int W = 4;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic             clk, rst_n, start, signed_mode;
    logic [W-1:0]     a, b;
    logic             busy, done;
    logic [2*W-1:0]   result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    seq_mul #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    // Cycles spent in RUN for a given multiplier.
    function automatic int lat_of(input logic [W-1:0] y, input logic sm);
        logic [W-1:0] m;
        int n;
        m = (sm && y[W-1]) ? (~y + W'(1)) : y;
        n = 1;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return EE ? n : W;
    endfunction

    // Reference: cycles remaining in RUN, pending product, and the visible result.
    int             rem_m;
    logic           done_m;
    logic           busy_m;
    logic [2*W-1:0] res_m, pend_m;

    assign busy_m = (rem_m != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_m  <= 0;
            done_m <= 1'b0;
            res_m  <= '0;
            pend_m <= '0;
        end else begin
            done_m <= 1'b0;
            if (rem_m != 0) begin
                rem_m <= rem_m - 1;
                if (rem_m == 1) begin
                    res_m  <= pend_m;
                    done_m <= 1'b1;
                end
            end else if (start) begin
                rem_m  <= lat_of(b, signed_mode);
                pend_m <= golden(a, b, signed_mode);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            chk("result", result, res_m);
            chk("busy_done_excl", busy & done, 0);
        end
    end

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic sm,
                          output int nbusy);
        int g;
        @(negedge clk);
        start = 1'b1; a = aa; b = bb; signed_mode = sm;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        g = 0;
        while (!done && g < 40) begin
            if (busy) nbusy++;
            g++;
            @(negedge clk);
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 40);
        chk("done_seen", done, 1);
    endtask

    initial begin
        int nb, ndone, t_prev;
        logic [2*W-1:0] r;
        logic [W-1:0]   ha [3];
        logic [W-1:0]   hb [3];
        logic [2*W-1:0] hx [3];
        ha = '{4'd2, 4'd5, 4'd15};
        hb = '{4'd3, 4'd6, 4'd1};
        hx = '{8'd6, 8'd30, 8'd15};
        t_prev = 0;

        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(4'hF, 4'hF, 1'b0, nb);
        chk("lat_15x15", nb, 4);
        chk("res_15x15", result, 8'hE1);
        chk("model_15x15", res_m, 8'hE1);
        @(negedge clk);
        chk("hold_15x15", result, 8'hE1);
        chk("done_single", done, 0);

        run_op(4'hD, 4'h5, 1'b1, nb);
        chk("res_m3x5", result, 8'hF1);
        chk("model_m3x5", res_m, 8'hF1);
        chk("lat_m3x5", nb, lat_of(4'h5, 1'b1));
        run_op(4'h8, 4'h8, 1'b1, nb);
        chk("res_m8xm8", result, 8'h40);
        run_op(4'h8, 4'h8, 1'b0, nb);
        chk("res_u8x8", result, 8'h40);

        // start pulses during RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 4'd3; b = 4'd13; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd7;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                r = result;
            end
            @(negedge clk);
        end
        chk("pulse_ndone", ndone, 1);
        chk("pulse_res", r, 8'h27);

        // start held high: back-to-back products
        @(negedge clk);
        start = 1'b1; a = ha[0]; b = hb[0]; signed_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_done();
            chk("held_res", result, hx[i]);
            if (i > 0) chk("held_gap", cyc - t_prev, lat_of(hb[i], 1'b0) + 1);
            t_prev = cyc;
            if (i < 2) begin
                a = ha[i+1];
                b = hb[i+1];
            end else begin
                start = 1'b0;
            end
        end

        // reset in RUN cycle 2
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd11; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        chk("rstmid_result", result, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_op(4'd6, 4'd7, 1'b0, nb);
        chk("after_rst_res", result, 8'h2A);
        chk("after_rst_lat", nb, lat_of(4'd7, 1'b0));

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                logic [7:0] v;
                v = i[7:0];
                run_op(v[7:4], v[3:0], m[0], nb);
                chk("exh_res", result, golden(v[7:4], v[3:0], m[0]));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

`ifdef SEQ_MUL_EARLY_EXIT_EN
        run_op(4'd5, 4'd1, 1'b0, nb);
        chk("ee_b1_lat", nb, 1);
        chk("ee_b1_res", result, 8'h05);
        run_op(4'd9, 4'd0, 1'b0, nb);
        chk("ee_b0_lat", nb, 1);
        chk("ee_b0_res", result, 8'h00);
        run_op(4'd3, 4'd8, 1'b0, nb);
        chk("ee_b8_lat", nb, 4);
        chk("ee_b8_res", result, 8'h18);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
